instr_fetch: RTL and testbench

Program-sequencing front end of the core: owns the 9-bit program counter, drives it to the combinational 20-bit instruction ROM, and splits each returned word into opcode and operand fields for the register file, ALU and data memory. It resolves all branches locally from a compare-flag register, honours a datapath stall, and sequences one program from a start address to its `done` instruction.

---
 rtl/isa_pkg.sv | 52 +++++
 rtl/instr_fetch_if.sv | 10 +
 rtl/inst_decode.sv | 32 +++
 rtl/instr_fetch.sv | 154 +++++++++++++++
 tb/tb_instr_fetch.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch front end, ALU and datapath:
// opcode encoding, instruction field positions and decode record.
package isa_pkg;
    localparam int PC_W   = 9;
    localparam int INST_W = 20;
    localparam int OP_W   = 5;
    localparam int FLD_W  = 5;
    localparam int OP_LSB = 15;
    localparam int FA_LSB = 10;
    localparam int FB_LSB = 5;
    localparam int FC_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_XOR  = 5'd2,
        OP_AND  = 5'd3,
        OP_SLL  = 5'd4,
        OP_SRL  = 5'd5,
        OP_CMP  = 5'd6,
        OP_BE   = 5'd7,
        OP_BL   = 5'd8,
        OP_BG   = 5'd9,
        OP_BA   = 5'd10,
        OP_MOV  = 5'd11,
        OP_LD   = 5'd12,
        OP_ST   = 5'd13,
        OP_DONE = 5'd14
    } opcode_e;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_EQ     = 3'd1,
        BR_LT     = 3'd2,
        BR_GT     = 3'd3,
        BR_ALWAYS = 3'd4
    } br_kind_e;

    typedef struct packed {
        logic     reg_we;
        logic     mem_rd;
        logic     mem_wr;
        logic     is_cmp;
        logic     is_done;
        logic     illegal;
        br_kind_e br;
    } dec_t;

    function automatic logic [FLD_W-1:0] field_at(input logic [INST_W-1:0] w, input int lsb);
        return w[lsb +: FLD_W];
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction ROM port: fetch address out, instruction word back in the same cycle.
interface instr_fetch_if #(
    parameter int AW = isa_pkg::PC_W
);
    logic [AW-1:0]               iptr;
    logic [isa_pkg::INST_W-1:0]  inst;

    modport master (output iptr, input inst);
    modport slave  (input iptr, output inst);
endinterface

// File: rtl/inst_decode.sv
// Purely combinational opcode classifier: write enables, branch kind,
// program completion and illegal-opcode detection.
module inst_decode
    import isa_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output dec_t            dec_o
);

    // Opcode to control record; anything outside 0-14 is an illegal no-op.
    always_comb begin
        dec_o = '0;
        case (op_i)
            OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_SLL, OP_SRL, OP_MOV: begin
                dec_o.reg_we = 1'b1;
            end
            OP_LD: begin
                dec_o.reg_we = 1'b1;
                dec_o.mem_rd = 1'b1;
            end
            OP_ST:   dec_o.mem_wr  = 1'b1;
            OP_CMP:  dec_o.is_cmp  = 1'b1;
            OP_BE:   dec_o.br      = BR_EQ;
            OP_BL:   dec_o.br      = BR_LT;
            OP_BG:   dec_o.br      = BR_GT;
            OP_BA:   dec_o.br      = BR_ALWAYS;
            OP_DONE: dec_o.is_done = 1'b1;
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Program sequencer: owns the PC, compare flags and retired count, fetches from
// the combinational ROM and issues each word's fields to the datapath.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int START_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [START_W-1:0] start_addr,
    input  logic               stall,
    input  logic               cmp_eq,
    input  logic               cmp_lt,
    input  logic               cmp_gt,
    instr_fetch_if.master      rom,
    output logic [FLD_W-1:0]   op,
    output logic [FLD_W-1:0]   fa,
    output logic [FLD_W-1:0]   fb,
    output logic [FLD_W-1:0]   fc,
    output logic               valid,
    output logic               reg_we,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    state_e             state_q;
    logic [START_W-1:0] pc_q, pc_d;
    logic [2:0]         flags_q, flags_d;   // {eq, lt, gt}
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q;
    logic               busy_q;
    logic               done_q;
    logic               take_br;
    dec_t               dec;

    inst_decode u_decode (
        .op_i  (op),
        .dec_o (dec)
    );

    assign rom.iptr = pc_q;
    assign op       = field_at(rom.inst, OP_LSB);
    assign fa       = field_at(rom.inst, FA_LSB);
    assign fb       = field_at(rom.inst, FB_LSB);
    assign fc       = field_at(rom.inst, FC_LSB);

    assign valid    = (state_q == ST_RUN) && !stall;
    assign reg_we   = valid && dec.reg_we;
    assign mem_rd   = valid && dec.mem_rd;
    assign mem_wr   = valid && dec.mem_wr;

    assign busy     = busy_q;
    assign done     = done_q;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

    // Branch resolution against the flags left by the most recent cmp.
    always_comb begin
        case (dec.br)
            BR_EQ:     take_br = flags_q[2];
            BR_LT:     take_br = flags_q[1];
            BR_GT:     take_br = flags_q[0];
            BR_ALWAYS: take_br = 1'b1;
            default:   take_br = 1'b0;
        endcase
    end

    // Next PC, flags and retired count if the current word issues this cycle.
    always_comb begin
        if (dec.is_done) begin
            pc_d = pc_q;
        end else if (take_br) begin
            pc_d = pc_q + rom.inst[START_W-1:0];
        end else begin
            pc_d = pc_q + START_W'(1);
        end

        if (dec.is_cmp) begin
            flags_d = {cmp_eq, cmp_lt, cmp_gt};
        end else begin
            flags_d = flags_q;
        end

        if (retired_q == {CNT_W{1'b1}}) begin
            retired_d = retired_q;
        end else begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            flags_q   <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        pc_q      <= start_addr;
                        flags_q   <= '0;
                        retired_q <= '0;
                        illegal_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (valid) begin
                        pc_q      <= pc_d;
                        flags_q   <= flags_d;
                        retired_q <= retired_d;
                        if (dec.illegal) begin
                            illegal_q <= 1'b1;
                        end
                        if (dec.is_done) begin
                            state_q <= ST_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program scenarios plus a randomized run
// checked against a program-level interpreter of the instruction set.
module tb_instr_fetch;
    localparam int CW      = 4;
    localparam int RET_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, start, stall, cmp_eq, cmp_lt, cmp_gt;
    logic [8:0]    start_addr;
    logic [4:0]    op, fa, fb, fc;
    logic          valid, reg_we, mem_rd, mem_wr, busy, done, illegal;
    logic [CW-1:0] retired;
    logic [19:0]   rom_mem [512];

    int total = 0;
    int bad   = 0;

    // Interpreter state: what the program should look like after each edge.
    logic [8:0] m_pc;
    bit         m_busy, m_fin, m_eq, m_lt, m_gt, m_ill;
    int         m_ret;

    instr_fetch_if rif ();
    assign rif.inst = rom_mem[rif.iptr];

    instr_fetch #(.START_W(9), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stall(stall),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .rom(rif),
        .op(op), .fa(fa), .fb(fb), .fc(fc), .valid(valid), .reg_we(reg_we),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] mk(input int opc, input int low);
        logic [4:0]  o;
        logic [14:0] l;
        o = opc[4:0];
        l = low[14:0];
        return {o, l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 1'b0; stall = 1'b0; start_addr = 9'd0;
        cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_gt = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic fill_rom(input logic [19:0] w);
        for (int a = 0; a < 512; a++) rom_mem[a] = w;
    endtask

    task automatic kick(input int sa);
        start = 1'b1;
        start_addr = 9'(sa);
        step();
        start = 1'b0;
    endtask

    // One clock of the ISA as described: sequencing, flags, branches, completion.
    task automatic model_step();
        logic [19:0] w;
        int opc, inc;
        bit taken;
        w = rom_mem[m_pc];
        opc = int'(w[19:15]);
        if (reset) begin
            m_busy = 0; m_fin = 0; m_pc = 9'd0; m_eq = 0; m_lt = 0; m_gt = 0;
            m_ill = 0; m_ret = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_pc = start_addr; m_eq = 0; m_lt = 0; m_gt = 0;
                m_ill = 0; m_ret = 0;
            end
        end else if (!stall) begin
            m_ret = (m_ret >= RET_MAX) ? RET_MAX : m_ret + 1;
            taken = (opc == 7 && m_eq) || (opc == 8 && m_lt) || (opc == 9 && m_gt) || (opc == 10);
            if (opc == 6) begin
                m_eq = cmp_eq; m_lt = cmp_lt; m_gt = cmp_gt;
            end
            if (opc == 14) begin
                m_busy = 0; m_fin = 1;
            end else begin
                if (opc >= 15) m_ill = 1;
                inc = taken ? int'(w[8:0]) : 1;
                m_pc = 9'((int'(m_pc) + inc) % 512);
            end
        end
    endtask

    task automatic test_reset();
        fill_rom(20'h00000);
        idle_in();
        reset = 1'b1;
        step();
        step();
        total++; if ({busy, done, illegal, valid, reg_we, mem_rd, mem_wr} !== 7'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000000", {busy, done, illegal, valid, reg_we, mem_rd, mem_wr});
        end
        total++; if (rif.iptr !== 9'h000 || retired !== 4'd0) begin
            bad++; $display("FAIL reset_pc_cnt got=%h/%0d exp=000/0", rif.iptr, retired);
        end
        rom_mem[0] = mk(13, 'h2345);
        #1;
        total++; if ({op, fc, mem_wr} !== {5'd13, 5'h05, 1'b0}) begin
            bad++; $display("FAIL reset_raw_fields got=%h/%h/%b exp=0d/05/0", op, fc, mem_wr);
        end
        reset = 1'b0;
    endtask

    task automatic test_done();
        do_reset();
        fill_rom(20'h00000);
        rom_mem[0] = 20'h70000;
        kick(0);
        total++; if ({busy, valid, reg_we} !== 3'b110 || rif.iptr !== 9'h000) begin
            bad++; $display("FAIL done_issue got=%b iptr=%h exp=110 iptr=000", {busy, valid, reg_we}, rif.iptr);
        end
        start = 1'b1; start_addr = 9'd5;
        step();
        start = 1'b0;
        total++; if ({done, busy} !== 2'b10 || retired !== 4'd1) begin
            bad++; $display("FAIL done_pulse got=%b ret=%0d exp=10 ret=1", {done, busy}, retired);
        end
        step();
        total++; if ({done, busy} !== 2'b00 || rif.iptr !== 9'h000) begin
            bad++; $display("FAIL finish_ignores_start got=%b iptr=%h exp=00 iptr=000", {done, busy}, rif.iptr);
        end
        kick(0);
        total++; if (busy !== 1'b1 || retired !== 4'd0) begin
            bad++; $display("FAIL restart_accept got=%b ret=%0d exp=1 ret=0", busy, retired);
        end
        step();
        step();
        total++; if (done !== 1'b0) begin
            bad++; $display("FAIL done_single got=%b exp=0", done);
        end
    endtask

    task automatic test_cmp_branch();
        logic [8:0] exp_pc;
        do_reset();
        fill_rom(20'h70000);
        rom_mem[4] = mk(6, 0);
        rom_mem[5] = mk(7, 4);
        for (int pass = 0; pass < 2; pass++) begin
            kick(4);
            cmp_eq = (pass == 0);
            step();
            cmp_eq = 1'b0;
            total++; if (rif.iptr !== 9'h005) begin
                bad++; $display("FAIL cmp_advance pass=%0d got=%h exp=005", pass, rif.iptr);
            end
            step();
            exp_pc = (pass == 0) ? 9'h009 : 9'h006;
            total++; if (rif.iptr !== exp_pc) begin
                bad++; $display("FAIL be_target pass=%0d got=%h exp=%h", pass, rif.iptr, exp_pc);
            end
            step();
            step();
        end
    endtask

    task automatic test_product();
        do_reset();
        fill_rom(20'h00000);
        rom_mem[9'h0F] = mk(6, 0);
        rom_mem[9'h10] = mk(8, 'h7FF3);
        rom_mem[9'h11] = mk(9, 4);
        rom_mem[9'h15] = mk(14, 0);
        kick(1);
        for (int k = 1; k <= 3; k++) begin
            total++; if (rif.iptr !== 9'(k) || busy !== 1'b1) begin
                bad++; $display("FAIL prod_seq got=%h busy=%b exp=%h busy=1", rif.iptr, busy, 9'(k));
            end
            step();
        end
        cmp_lt = 1'b1;
        for (int k = 0; k < 30 && rif.iptr !== 9'h010; k++) step();
        step();
        total++; if (rif.iptr !== 9'h003) begin
            bad++; $display("FAIL bl_back got=%h exp=003", rif.iptr);
        end
        cmp_lt = 1'b0; cmp_gt = 1'b1;
        for (int k = 0; k < 30 && rif.iptr !== 9'h011; k++) step();
        total++; if (rif.iptr !== 9'h011) begin
            bad++; $display("FAIL bl_fallthrough got=%h exp=011", rif.iptr);
        end
        step();
        total++; if (rif.iptr !== 9'h015) begin
            bad++; $display("FAIL bg_fwd got=%h exp=015", rif.iptr);
        end
        step();
        total++; if (done !== 1'b1) begin
            bad++; $display("FAIL prod_done got=%b exp=1", done);
        end
        idle_in();
        step();
    endtask

    task automatic test_stall();
        do_reset();
        fill_rom(mk(14, 0));
        rom_mem[9'h20] = mk(13, 3);
        rom_mem[9'h21] = mk(6, 0);
        rom_mem[9'h22] = mk(7, 3);
        kick(9'h20);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if ({valid, mem_wr} !== 2'b00) begin
                bad++; $display("FAIL stall_en got=%b exp=00", {valid, mem_wr});
            end
            step();
            total++; if (rif.iptr !== 9'h020 || retired !== 4'd0) begin
                bad++; $display("FAIL stall_hold got=%h/%0d exp=020/0", rif.iptr, retired);
            end
        end
        stall = 1'b0;
        #1;
        total++; if ({valid, mem_wr} !== 2'b11) begin
            bad++; $display("FAIL st_issue got=%b exp=11", {valid, mem_wr});
        end
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) step();
        total++; if (rif.iptr !== 9'h021 || retired !== 4'd1) begin
            bad++; $display("FAIL stall_cmp_hold got=%h/%0d exp=021/1", rif.iptr, retired);
        end
        stall = 1'b0; cmp_eq = 1'b1;
        step();
        cmp_eq = 1'b0;
        step();
        total++; if (rif.iptr !== 9'h025 || retired !== 4'd3) begin
            bad++; $display("FAIL be_after_stall got=%h/%0d exp=025/3", rif.iptr, retired);
        end
        step();
        step();
    endtask

    task automatic test_illegal_wrap();
        do_reset();
        fill_rom(mk(14, 0));
        rom_mem[9'h40]  = mk(31, 'h1234);
        rom_mem[9'h41]  = mk(10, 'h01BE);
        rom_mem[9'h1FF] = mk(10, 1);
        kick(9'h40);
        total++; if ({valid, reg_we, mem_rd, mem_wr} !== 4'b1000 || op !== 5'h1F) begin
            bad++; $display("FAIL illegal_noop got=%b op=%h exp=1000 op=1f", {valid, reg_we, mem_rd, mem_wr}, op);
        end
        step();
        total++; if (rif.iptr !== 9'h041 || illegal !== 1'b1) begin
            bad++; $display("FAIL illegal_set got=%h/%b exp=041/1", rif.iptr, illegal);
        end
        step();
        total++; if (rif.iptr !== 9'h1FF) begin
            bad++; $display("FAIL ba_to_top got=%h exp=1ff", rif.iptr);
        end
        step();
        total++; if (rif.iptr !== 9'h000 || illegal !== 1'b1) begin
            bad++; $display("FAIL pc_wrap got=%h/%b exp=000/1", rif.iptr, illegal);
        end
        step();
        step();
        total++; if (illegal !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL illegal_sticky got=%b busy=%b exp=1 busy=0", illegal, busy);
        end
        kick(0);
        total++; if (illegal !== 1'b0) begin
            bad++; $display("FAIL illegal_clear got=%b exp=0", illegal);
        end
        step();
        step();
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        fill_rom(20'h00000);
        rom_mem[9'h30] = mk(10, 0);
        kick(9'h30);
        for (int k = 0; k < 20; k++) step();
        total++; if (retired !== 4'd15 || rif.iptr !== 9'h030 || busy !== 1'b1) begin
            bad++; $display("FAIL retired_sat got=%0d/%h exp=15/030", retired, rif.iptr);
        end
        do_reset();
        rom_mem[9'h30] = 20'h00000;
        kick(9'h28);
        step();
        start = 1'b1; start_addr = 9'h100;
        step();
        start = 1'b0;
        total++; if (rif.iptr !== 9'h02A || busy !== 1'b1 || retired !== 4'd2) begin
            bad++; $display("FAIL run_ignores_start got=%h/%b/%0d exp=02a/1/2", rif.iptr, busy, retired);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if ({busy, done, valid} !== 3'b000 || rif.iptr !== 9'h000 || retired !== 4'd0) begin
            bad++; $display("FAIL reset_in_run got=%b/%h/%0d exp=000/000/0", {busy, done, valid}, rif.iptr, retired);
        end
    endtask

    task automatic test_random();
        logic [19:0] w;
        int opc, r;
        logic [3:0] exp_en;
        bit ev;
        for (int a = 0; a < 512; a++) begin
            r = $urandom_range(0, 99);
            if (r < 4)       opc = 14;
            else if (r < 8)  opc = $urandom_range(15, 31);
            else if (r < 24) opc = $urandom_range(7, 10);
            else if (r < 36) opc = 6;
            else begin
                opc = $urandom_range(0, 9);
                if (opc >= 6) opc = opc + 5;
            end
            rom_mem[a] = mk(opc, $urandom_range(0, 32767));
        end
        do_reset();
        m_busy = 0; m_fin = 0; m_pc = 9'd0; m_eq = 0; m_lt = 0; m_gt = 0; m_ill = 0; m_ret = 0;
        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            start      = ($urandom_range(0, 2) == 0);
            start_addr = 9'($urandom);
            stall      = ($urandom_range(0, 3) == 0);
            cmp_eq     = 1'($urandom);
            cmp_lt     = 1'($urandom);
            cmp_gt     = 1'($urandom);
            #1;
            w   = rom_mem[m_pc];
            opc = int'(w[19:15]);
            ev  = m_busy && !stall;
            exp_en = {ev, ev && (opc <= 5 || opc == 11 || opc == 12), ev && (opc == 12), ev && (opc == 13)};
            total++; if ({valid, reg_we, mem_rd, mem_wr} !== exp_en) begin
                bad++; $display("FAIL rnd_enables cyc=%0d got=%b exp=%b", c, {valid, reg_we, mem_rd, mem_wr}, exp_en);
            end
            total++; if ({op, fa, fb, fc} !== w) begin
                bad++; $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", c, {op, fa, fb, fc}, w);
            end
            model_step();
            step();
            total++; if ({rif.iptr, busy, done, illegal} !== {m_pc, m_busy, m_fin, m_ill}) begin
                bad++; $display("FAIL rnd_state cyc=%0d got=%h/%b%b%b exp=%h/%b%b%b", c,
                                rif.iptr, busy, done, illegal, m_pc, m_busy, m_fin, m_ill);
            end
            total++; if (retired !== CW'(m_ret)) begin
                bad++; $display("FAIL rnd_retired cyc=%0d got=%0d exp=%0d", c, retired, m_ret);
            end
        end
        idle_in();
        reset = 1'b0;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        test_reset();
        test_done();
        test_cmp_branch();
        test_product();
        test_stall();
        test_illegal_wrap();
        test_saturate_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
